exu: RTL and testbench
======================

# exu

Execute stage of the multi-cycle NPC core. It sits directly downstream of `adu`: it accepts the decoded operand bus on a valid/ready handshake, holds it in a one-entry pipeline register and computes the ALU result, the rd write-back value and the jump/branch redirect. It presents the result to the LSU stage on a second valid/ready handshake, and latches a halt on `ebreak`.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `adu_valid_i`  in  1  the ADU bus holds a valid instruction.
- `exu_ready_o`  out  1  exu can accept a bus this cycle.
- `adu_exu_bus_i`  in  `ADU_EXU_BUS_WIDTH` (233)  fields, MSB first:
  - `res_from_compare`, `compare_result`, `excp_flush`, `xret_flush`, `break_signal`
  - `snpc`[32], `src1`[32], `src2`[32], `rs2_value`[32], `alu_op`[6]
  - `res_from_mem`, `res_from_csr`, `gr_we`, `csr_we`
  - `mem_re`[4], `mem_we`[4], `rd`[5], `jmp_flag`
  - `csr_addr`[12], `csr_wdata`[32], `csr_value`[32]
- `exu_valid_o`  out  1  the LSU bus is valid.
- `lsu_ready_i`  in  1  the LSU accepts the bus this cycle.
- `exu_lsu_bus_o`  out  `EXU_LSU_BUS_WIDTH` (158)  fields, MSB first:
  - `excp_flush`, `xret_flush`
  - `alu_result`[32], `store_data`[32], `rd_wdata`[32]
  - `res_from_mem`, `gr_we`, `csr_we`
  - `mem_re`[4], `mem_we`[4], `rd`[5], `csr_addr`[12], `csr_wdata`[32]
- `redirect_valid_o`  out  1  one-cycle pulse: take `dnpc_o` as the next PC.
- `dnpc_o`  out  32  redirect target.
- `halt_o`  out  1  sticky `ebreak` indication.

## Operation
- Storage: pipeline register `bus_q` and flag `full_q`. Two states:
  - EMPTY (`full_q`=0).
  - FULL (`full_q`=1).
- Accept condition: `exu_ready_o = !halt_o && (!full_q || lsu_ready_i)`. A transfer occurs when `adu_valid_i && exu_ready_o`; `bus_q` loads and `full_q` sets.
- Leave condition: FULL with `lsu_ready_i` and no new transfer returns to EMPTY. A simultaneous leave and accept stays FULL with the new bus loaded (back-to-back, no bubble).
- `exu_valid_o = full_q`. Every output field is combinational from `bus_q`.
- ALU, selected by `alu_op[5:4]`:
  - `11` adder: `src1 + src2`, or `src1 - src2` when bit0=1.
  - `01` logic, on `[3:1]`: `011` xor, `111` or, `100` and.
  - `10` shifter, amount `src2[4:0]`, on `[1:0]`: `00` sll, `01` srl, `11` sra (arithmetic).
  - `00` or any undefined code yields 0.
  - All results are mod 2^32.
- `rd_wdata` priority:
  1. `jmp_flag`: `snpc`.
  2. `res_from_csr`: `csr_value`.
  3. `res_from_compare`: `{31'b0, compare_result}`.
  4. Otherwise: `alu_result`.
- `store_data = rs2_value`. `csr_wdata`, `mem_re`, `mem_we` and `rd` pass through unchanged.
- Redirect:
  - `dnpc_o = {alu_result[31:1], 1'b0}`.
  - `redirect_valid_o` is high only in the first FULL cycle after each transfer, and only if `jmp_flag`. A one-bit `fresh_q` tracks this; it sets on transfer and clears the next cycle.
- Halt: `halt_o` sets on the clock edge on which a bus with `break_signal` = 1 leaves to the LSU, and stays set until reset. While `halt_o` is set, `exu_ready_o` = 0 and no further bus is accepted.
- `excp_flush` and `xret_flush` are forwarded only; exu takes no action on them.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `full_q`, `fresh_q` and `halt_o` clear; `bus_q` zeroes.
  - Resulting outputs: `exu_valid_o`=0, `redirect_valid_o`=0, `dnpc_o`=0, `exu_lsu_bus_o`=0, `exu_ready_o`=1.
- Latency: a bus accepted at edge N is on `exu_lsu_bus_o` during cycle N+1; the redirect pulse is in cycle N+1.
- Throughput: one instruction per cycle while `lsu_ready_i`=1.
- Stall: with `lsu_ready_i`=0, the output bus holds stable for the whole stall, and `redirect_valid_o` does not re-pulse.
- Reset during FULL drops the held instruction; nothing is emitted.
- `adu_valid_i` while `exu_ready_o`=0: the bus is ignored. Upstream must hold the bus.

## Structure
- The `riscv_param.vh` header holds:
  - The ALU op codes as `ALU_ADD`, `ALU_SUB`, `ALU_XOR`, `ALU_OR`, `ALU_AND`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`.
  - `ADU_EXU_BUS_WIDTH` (233) and `EXU_LSU_BUS_WIDTH` (158).
- Sub-module: `alu`, purely combinational (`alu_op`, `src1`, `src2` → `alu_result`), so later stages can reuse it. The FSM, pipeline register and muxes stay in `exu`.

## Test plan
- add, `src1`=0xFFFFFFFF, `src2`=1, `lsu_ready_i`=1 → next cycle `alu_result`=0 and `rd_wdata`=0; `exu_valid_o` is high for one cycle.
- sra: `src1`=0x80000000, `src2`=4 → `alu_result`=0xF8000000. srl on the same operands → 0x08000000.
- jalr: `jmp_flag`=1, `src1`=0x80000003, `src2`=0, `snpc`=0x80000010 → `dnpc_o`=0x80000002 with a single-cycle `redirect_valid_o`, and `rd_wdata`=0x80000010.
- Backpressure: hold `lsu_ready_i`=0 for 3 cycles with `adu_valid_i`=1 → bus stable and `exu_ready_o`=0 throughout. Raise `lsu_ready_i` → the held instruction and the next one transfer on consecutive edges.
- `ebreak` leaves to the LSU → `halt_o`=1 and `exu_ready_o`=0 afterwards. Assert `rst_ni`=0 mid-cycle → `halt_o` and `exu_valid_o` clear immediately.
- csrrs: `res_from_csr`=1, `csr_value`=0x1800 → `rd_wdata`=0x1800, and `csr_wdata` equals the input.

Source files
------------

// File: rtl/exu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_pkg
// Description : Shared types and constants for the NPC execute stage:
//               ALU op codes, ADU->EXU and EXU->LSU bus layouts and the
//               pipeline-register state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package exu_pkg;

  localparam int ALU_OP_W          = 6;
  localparam int ADU_EXU_BUS_WIDTH = 233;
  localparam int EXU_LSU_BUS_WIDTH = 158;

  // alu_op[5:4] selects the unit; the low bits select the operation.
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'b11_0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'b11_0001;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 6'b01_0110;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 6'b01_1110;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 6'b01_1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 6'b10_0000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 6'b10_0001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 6'b10_0011;

  // Decoded operand bus from the ADU, MSB first.
  typedef struct packed {
    logic                res_from_compare;
    logic                compare_result;
    logic                excp_flush;
    logic                xret_flush;
    logic                break_signal;
    logic [31:0]         snpc;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic [31:0]         rs2_value;
    logic [ALU_OP_W-1:0] alu_op;
    logic                res_from_mem;
    logic                res_from_csr;
    logic                gr_we;
    logic                csr_we;
    logic [3:0]          mem_re;
    logic [3:0]          mem_we;
    logic [4:0]          rd;
    logic                jmp_flag;
    logic [11:0]         csr_addr;
    logic [31:0]         csr_wdata;
    logic [31:0]         csr_value;
  } adu_exu_bus_t;

  // Result bus toward the LSU, MSB first.
  typedef struct packed {
    logic        excp_flush;
    logic        xret_flush;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] rd_wdata;
    logic        res_from_mem;
    logic        gr_we;
    logic        csr_we;
    logic [3:0]  mem_re;
    logic [3:0]  mem_we;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
  } exu_lsu_bus_t;

  // One-entry pipeline register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } exu_state_t;

  // Write-back value selection: jump link beats CSR read beats compare.
  function automatic logic [31:0] select_rd_wdata(
    input logic        jmp_flag,
    input logic        res_from_csr,
    input logic        res_from_compare,
    input logic        compare_result,
    input logic [31:0] snpc,
    input logic [31:0] csr_value,
    input logic [31:0] alu_result
  );
    logic [31:0] sel;
    if (jmp_flag)              sel = snpc;
    else if (res_from_csr)     sel = csr_value;
    else if (res_from_compare) sel = {31'b0, compare_result};
    else                       sel = alu_result;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exu_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Purely combinational integer ALU (adder, logic, shifter).
//               Undefined op codes produce zero. Shareable by later stages.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  output logic [XLEN-1:0]     alu_result
);

  logic [4:0] shamt;
  assign shamt = src2[4:0];

  // Unit select on alu_op[5:4], operation select on the low bits.
  always_comb begin
    alu_result = '0;
    case (alu_op[5:4])
      2'b11: begin
        if (alu_op[0]) alu_result = src1 - src2;
        else           alu_result = src1 + src2;
      end
      2'b01: begin
        case (alu_op[3:1])
          3'b011:  alu_result = src1 ^ src2;
          3'b111:  alu_result = src1 | src2;
          3'b100:  alu_result = src1 & src2;
          default: alu_result = '0;
        endcase
      end
      2'b10: begin
        case (alu_op[1:0])
          2'b00:   alu_result = src1 << shamt;
          2'b01:   alu_result = src1 >> shamt;
          2'b11:   alu_result = $signed(src1) >>> shamt;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/exu.sv
`default_nettype none
// ============================================================================
// Module      : exu
// Description : Execute stage of the multi-cycle NPC core. One-entry
//               pipeline register between ADU and LSU handshakes, ALU,
//               write-back select, jump redirect and sticky ebreak halt.
// Revision    : 1.0 - initial release
// ============================================================================
module exu
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         adu_valid_i,
  output logic                         exu_ready_o,
  input  logic [ADU_EXU_BUS_WIDTH-1:0] adu_exu_bus_i,
  output logic                         exu_valid_o,
  input  logic                         lsu_ready_i,
  output logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_o,
  output logic                         redirect_valid_o,
  output logic [XLEN-1:0]              dnpc_o,
  output logic                         halt_o
);

  exu_state_t   state_q;
  exu_state_t   state_d;
  adu_exu_bus_t bus_q;
  logic         full_q;
  logic         fresh_q;
  logic         halt_q;
  logic         transfer;
  logic         leave;
  logic [31:0]  alu_result;
  exu_lsu_bus_t lsu_bus;

  assign full_q   = (state_q == ST_FULL);
  // Halt blocks intake; otherwise accept when empty or draining this cycle.
  assign exu_ready_o = !halt_q && (!full_q || lsu_ready_i);
  assign transfer    = adu_valid_i && exu_ready_o;
  assign leave       = full_q && lsu_ready_i;

  // Occupancy state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  // Next occupancy: a simultaneous leave and accept stays FULL (no bubble).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (transfer)         state_d = ST_FULL;
      ST_FULL: begin
        if (transfer)                 state_d = ST_FULL;
        else if (lsu_ready_i)         state_d = ST_EMPTY;
      end
      default:                        state_d = ST_EMPTY;
    endcase
  end

  // Pipeline register loads on every accepted transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       bus_q <= '0;
    else if (transfer) bus_q <= adu_exu_bus_i;
  end

  // First-cycle marker so a stalled jump redirects only once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fresh_q <= 1'b0;
    else         fresh_q <= transfer;
  end

  // Sticky halt, set as an ebreak hands off to the LSU.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           halt_q <= 1'b0;
    else if (leave && bus_q.break_signal)  halt_q <= 1'b1;
  end

  alu #(
    .XLEN (32)
  ) u_alu (
    .alu_op     (bus_q.alu_op),
    .src1       (bus_q.src1),
    .src2       (bus_q.src2),
    .alu_result (alu_result)
  );

  // Result bus assembly, all combinational from the held operand bus.
  always_comb begin
    lsu_bus              = '0;
    lsu_bus.excp_flush   = bus_q.excp_flush;
    lsu_bus.xret_flush   = bus_q.xret_flush;
    lsu_bus.alu_result   = alu_result;
    lsu_bus.store_data   = bus_q.rs2_value;
    lsu_bus.rd_wdata     = select_rd_wdata(bus_q.jmp_flag, bus_q.res_from_csr,
                                           bus_q.res_from_compare,
                                           bus_q.compare_result, bus_q.snpc,
                                           bus_q.csr_value, alu_result);
    lsu_bus.res_from_mem = bus_q.res_from_mem;
    lsu_bus.gr_we        = bus_q.gr_we;
    lsu_bus.csr_we       = bus_q.csr_we;
    lsu_bus.mem_re       = bus_q.mem_re;
    lsu_bus.mem_we       = bus_q.mem_we;
    lsu_bus.rd           = bus_q.rd;
    lsu_bus.csr_addr     = bus_q.csr_addr;
    lsu_bus.csr_wdata    = bus_q.csr_wdata;
  end

  assign exu_lsu_bus_o    = lsu_bus;
  assign exu_valid_o      = full_q;
  assign halt_o           = halt_q;
  // Jump target is the ALU sum with bit 0 cleared (jalr semantics).
  assign dnpc_o           = {alu_result[31:1], 1'b0};
  assign redirect_valid_o = full_q && fresh_q && bus_q.jmp_flag;

endmodule
`default_nettype wire

// File: tb/tb_exu.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu
// Description : Self-checking bench for exu with an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu;
  import exu_pkg::*;

  logic                         clk;
  logic                         rst_n;
  logic                         adu_valid;
  logic                         exu_ready;
  adu_exu_bus_t                 adu_bus;
  logic                         exu_valid;
  logic                         lsu_ready;
  logic [EXU_LSU_BUS_WIDTH-1:0] bus_o;
  logic                         redirect;
  logic [31:0]                  dnpc;
  logic                         halt;
  exu_lsu_bus_t                 ob;

  int total = 0;
  int bad   = 0;
  exu_lsu_bus_t exp_q[$];
  exu_lsu_bus_t mon_exp;

  assign ob = bus_o;

  exu #(.XLEN(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .adu_valid_i      (adu_valid),
    .exu_ready_o      (exu_ready),
    .adu_exu_bus_i    (adu_bus),
    .exu_valid_o      (exu_valid),
    .lsu_ready_i      (lsu_ready),
    .exu_lsu_bus_o    (bus_o),
    .redirect_valid_o (redirect),
    .dnpc_o           (dnpc),
    .halt_o           (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exu_lsu_bus_t model(input adu_exu_bus_t b);
    logic [31:0]  a;
    exu_lsu_bus_t o;
    case (b.alu_op)
      ALU_ADD: a = b.src1 + b.src2;
      ALU_SUB: a = b.src1 - b.src2;
      ALU_XOR: a = b.src1 ^ b.src2;
      ALU_OR:  a = b.src1 | b.src2;
      ALU_AND: a = b.src1 & b.src2;
      ALU_SLL: a = b.src1 << b.src2[4:0];
      ALU_SRL: a = b.src1 >> b.src2[4:0];
      ALU_SRA: a = $signed(b.src1) >>> b.src2[4:0];
      default: a = 32'h0;
    endcase
    o = '0;
    o.excp_flush   = b.excp_flush;
    o.xret_flush   = b.xret_flush;
    o.alu_result   = a;
    o.store_data   = b.rs2_value;
    if (b.jmp_flag)              o.rd_wdata = b.snpc;
    else if (b.res_from_csr)     o.rd_wdata = b.csr_value;
    else if (b.res_from_compare) o.rd_wdata = {31'b0, b.compare_result};
    else                         o.rd_wdata = a;
    o.res_from_mem = b.res_from_mem;
    o.gr_we        = b.gr_we;
    o.csr_we       = b.csr_we;
    o.mem_re       = b.mem_re;
    o.mem_we       = b.mem_we;
    o.rd           = b.rd;
    o.csr_addr     = b.csr_addr;
    o.csr_wdata    = b.csr_wdata;
    return o;
  endfunction

  function automatic adu_exu_bus_t mk(input logic [5:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2);
    adu_exu_bus_t b;
    b = '0;
    b.alu_op = op;
    b.src1   = s1;
    b.src2   = s2;
    b.rd     = 5'd5;
    b.gr_we  = 1'b1;
    return b;
  endfunction

  function automatic adu_exu_bus_t rnd_bus();
    adu_exu_bus_t b;
    logic [5:0] ops [10];
    ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL,
            ALU_SRA, 6'b000000, 6'b010000};
    b = '0;
    b.res_from_compare = 1'($urandom_range(1));
    b.compare_result   = 1'($urandom_range(1));
    b.excp_flush       = 1'($urandom_range(1));
    b.xret_flush       = 1'($urandom_range(1));
    b.snpc             = $urandom();
    b.src1             = $urandom();
    b.src2             = $urandom();
    b.rs2_value        = $urandom();
    b.alu_op           = ops[$urandom_range(9)];
    b.res_from_mem     = 1'($urandom_range(1));
    b.res_from_csr     = 1'($urandom_range(1));
    b.gr_we            = 1'($urandom_range(1));
    b.csr_we           = 1'($urandom_range(1));
    b.mem_re           = 4'($urandom_range(15));
    b.mem_we           = 4'($urandom_range(15));
    b.rd               = 5'($urandom_range(31));
    b.jmp_flag         = 1'($urandom_range(1));
    b.csr_addr         = 12'($urandom_range(4095));
    b.csr_wdata        = $urandom();
    b.csr_value        = $urandom();
    return b;
  endfunction

  // Output monitor: every LSU handshake pops and compares one expectation.
  always @(negedge clk) begin
    if (rst_n && exu_valid && lsu_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: got %h, expected no output", bus_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus_o !== mon_exp) begin
          bad++;
          $display("FAIL lsu_bus: got %h expected %h", bus_o, mon_exp);
        end
      end
    end
  end

  // Present a bus and hold it until exu accepts it; returns 1 ns after the
  // accepting edge with adu_valid still asserted.
  task automatic send(input adu_exu_bus_t b);
    int   waited = 0;
    logic done   = 1'b0;
    adu_valid = 1'b1;
    adu_bus   = b;
    while (!done) begin
      @(negedge clk);
      if (exu_ready) begin
        exp_q.push_back(model(b));
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited > 20) begin
          total++;
          bad++;
          $display("FAIL send_timeout: got ready=0 for %0d cycles, expected accept", waited);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adu_valid = 1'b0; adu_bus = '0; lsu_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++;
    if ({exu_valid, redirect, halt, exu_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_flags: got v/r/h/rdy=%b expected 0001",
               {exu_valid, redirect, halt, exu_ready});
    end
    total++;
    if (dnpc !== 32'h0 || bus_o !== '0) begin
      bad++;
      $display("FAIL reset_bus: got dnpc=%h bus=%h expected zeros", dnpc, bus_o);
    end
  endtask

  task automatic test_add();
    lsu_ready = 1'b1;
    send(mk(ALU_ADD, 32'hFFFF_FFFF, 32'h1));
    adu_valid = 1'b0;
    total++;
    if (exu_valid !== 1'b1 || ob.alu_result !== 32'h0 || ob.rd_wdata !== 32'h0) begin
      bad++;
      $display("FAIL add_wrap: got v=%b alu=%h rd=%h expected 1/0/0",
               exu_valid, ob.alu_result, ob.rd_wdata);
    end
    tick();
    total++;
    if (exu_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_single_cycle: got valid=%b expected 0", exu_valid);
    end
  endtask

  task automatic test_shift();
    lsu_ready = 1'b1;
    send(mk(ALU_SRA, 32'h8000_0000, 32'd4));
    total++;
    if (ob.alu_result !== 32'hF800_0000) begin
      bad++;
      $display("FAIL sra: got %h expected f8000000", ob.alu_result);
    end
    send(mk(ALU_SRL, 32'h8000_0000, 32'd4));
    adu_valid = 1'b0;
    total++;
    if (ob.alu_result !== 32'h0800_0000) begin
      bad++;
      $display("FAIL srl: got %h expected 08000000", ob.alu_result);
    end
    tick();
  endtask

  task automatic test_jalr();
    adu_exu_bus_t b;
    b = mk(ALU_ADD, 32'h8000_0003, 32'h0);
    b.jmp_flag = 1'b1;
    b.snpc     = 32'h8000_0010;
    lsu_ready  = 1'b0;
    send(b);
    adu_valid = 1'b0;
    total++;
    if (dnpc !== 32'h8000_0002 || redirect !== 1'b1 || ob.rd_wdata !== 32'h8000_0010) begin
      bad++;
      $display("FAIL jalr: got dnpc=%h redir=%b rd=%h expected 80000002/1/80000010",
               dnpc, redirect, ob.rd_wdata);
    end
    tick();
    total++;
    if (redirect !== 1'b0 || exu_valid !== 1'b1) begin
      bad++;
      $display("FAIL jalr_stall_pulse: got redir=%b valid=%b expected 0/1", redirect, exu_valid);
    end
    lsu_ready = 1'b1;
    tick();
    total++;
    if (exu_valid !== 1'b0) begin
      bad++;
      $display("FAIL jalr_drain: got valid=%b expected 0", exu_valid);
    end
  endtask

  task automatic test_csr();
    adu_exu_bus_t b;
    b = mk(ALU_OR, 32'h1234, 32'h0);
    b.res_from_csr = 1'b1;
    b.csr_value    = 32'h0000_1800;
    b.csr_wdata    = 32'hA5A5_0F0F;
    b.csr_we       = 1'b1;
    b.csr_addr     = 12'h300;
    lsu_ready = 1'b1;
    send(b);
    adu_valid = 1'b0;
    total++;
    if (ob.rd_wdata !== 32'h0000_1800 || ob.csr_wdata !== 32'hA5A5_0F0F) begin
      bad++;
      $display("FAIL csrrs: got rd=%h csr_wdata=%h expected 00001800/a5a50f0f",
               ob.rd_wdata, ob.csr_wdata);
    end
    tick();
  endtask

  task automatic test_backpressure();
    adu_exu_bus_t a;
    adu_exu_bus_t b;
    a = rnd_bus(); a.break_signal = 1'b0;
    b = rnd_bus(); b.break_signal = 1'b0;
    lsu_ready = 1'b0;
    send(a);
    adu_bus = b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (exu_ready !== 1'b0 || bus_o !== model(a)) begin
        bad++;
        $display("FAIL stall_%0d: got ready=%b bus=%h expected 0/%h", i, exu_ready, bus_o, model(a));
      end
      tick();
    end
    lsu_ready = 1'b1;
    @(negedge clk);
    total++;
    if (exu_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_ready: got %b expected 1", exu_ready);
    end
    if (exu_ready) exp_q.push_back(model(b));
    tick();
    adu_valid = 1'b0;
    total++;
    if (exu_valid !== 1'b1 || bus_o !== model(b)) begin
      bad++;
      $display("FAIL release_next: got valid=%b bus=%h expected 1/%h", exu_valid, bus_o, model(b));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    adu_exu_bus_t b;
    time t0;
    lsu_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 24; i++) begin
      b = rnd_bus();
      b.break_signal = 1'b0;
      send(b);
    end
    adu_valid = 1'b0;
    total++;
    if (($time - t0) != 240) begin
      bad++;
      $display("FAIL throughput: got %0t ns for 24 transfers expected 240", $time - t0);
    end
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_halt_reset();
    adu_exu_bus_t e;
    adu_exu_bus_t c;
    e = mk(ALU_ADD, 32'h10, 32'h20);
    e.break_signal = 1'b1;
    c = rnd_bus(); c.break_signal = 1'b0;
    lsu_ready = 1'b1;
    send(e);
    send(c);
    lsu_ready = 1'b0;
    adu_bus   = rnd_bus();
    total++;
    if (halt !== 1'b1 || exu_ready !== 1'b0 || exu_valid !== 1'b1) begin
      bad++;
      $display("FAIL halt_set: got halt=%b ready=%b valid=%b expected 1/0/1",
               halt, exu_ready, exu_valid);
    end
    lsu_ready = 1'b1;
    tick();
    tick();
    total++;
    if (exu_ready !== 1'b0 || halt !== 1'b1 || exu_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_block: got ready=%b halt=%b valid=%b expected 0/1/0",
               exu_ready, halt, exu_valid);
    end
    lsu_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (halt !== 1'b0 || exu_valid !== 1'b0 || exu_ready !== 1'b1 || bus_o !== '0) begin
      bad++;
      $display("FAIL async_reset: got halt=%b valid=%b ready=%b bus=%h expected 0/0/1/0",
               halt, exu_valid, exu_ready, bus_o);
    end
    adu_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_full();
    lsu_ready = 1'b0;
    send(rnd_bus());
    adu_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (exu_valid !== 1'b0 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL reset_full: got valid=%b redir=%b expected 0/0", exu_valid, redirect);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    lsu_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_jalr();
    test_csr();
    test_backpressure();
    test_back_to_back();
    test_halt_reset();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
